// File: rtl/sys_seq_ctrl_pkg.sv
// Shared types for the systemizer sequencing controller: FSM states, job
// result codes and a counter-width helper.
package sys_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KICK,
      RUN_WAIT,
      DRAIN,
      FINISH
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK   = 2'd0,
      ERR_SING = 2'd1,
      ERR_TMO  = 2'd2
   } err_t;

   // Bits needed to index n items; never less than one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sys_seq_ctrl_if.sv
// Stream, memory and systemizer handshake bundle for sys_seq_ctrl.
// master = controller side, slave = environment side.
interface sys_seq_ctrl_if #(
   parameter int W  = 32,
   parameter int AW = 3
);

   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;

   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;

   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata;
   logic          mem_owner;

   logic          sys_start;
   logic          sys_done;
   logic          sys_fail;

   modport master (
      input  in_data, in_valid, out_ready, mem_rdata, sys_done, sys_fail,
      output in_ready, out_data, out_valid, mem_addr, mem_wr, mem_wdata,
             mem_owner, sys_start
   );

   modport slave (
      output in_data, in_valid, out_ready, mem_rdata, sys_done, sys_fail,
      input  in_ready, out_data, out_valid, mem_addr, mem_wr, mem_wdata,
             mem_owner, sys_start
   );

endinterface

// File: rtl/sys_seq_ctrl_skid_buf.sv
// Two-entry skid buffer for the drain stream. in_ready means "a beat arriving
// next cycle will fit", so a read issued now is always absorbed.
module skid_buf #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] slot [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic [1:0]   count_nx;
   logic         push;
   logic         pop;

   always_comb begin
      out_valid = (count != 2'd0);
      out_data  = slot[rd_ptr];
      pop       = out_valid & out_ready;
      push      = in_valid & ((count != 2'd2) | pop);
      count_nx  = count + {1'b0, push} - {1'b0, pop};
      // Look ahead one cycle to cover the memory read latency.
      in_ready  = (count_nx < 2'd2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         count <= count_nx;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) slot[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/sys_seq_ctrl.sv
// Job sequencer: streams ROWS words into memory, hands memory to the
// systemizer, waits for completion or timeout, then drains memory out.
module sys_seq_ctrl
   import sys_seq_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int W       = 32,
   parameter int TIMEOUT = 65535,
   parameter int AW      = cnt_width(ROWS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   output logic [1:0]  err,
   sys_seq_ctrl_if.master bus
);

   localparam int            TW       = cnt_width(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST     = AW'(ROWS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nx;
   err_t          err_q;

   logic [AW-1:0] addr_cnt;
   logic          addr_end;
   logic [AW-1:0] beat_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          rd_pend;

   logic          load_beat;
   logic          rd_issue;
   logic          out_beat;
   logic          tmo_hit;

   logic          sk_ready;
   logic          sk_valid;
   logic [W-1:0]  sk_data;
   logic          sk_out_ready;

   assign err          = err_q;
   assign sk_out_ready = (state == DRAIN) & bus.out_ready;

   skid_buf #(
      .W (W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (bus.mem_rdata),
      .in_valid  (rd_pend),
      .in_ready  (sk_ready),
      .out_data  (sk_data),
      .out_valid (sk_valid),
      .out_ready (sk_out_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      done          = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = sk_data;
      bus.mem_addr  = '0;
      bus.mem_wr    = 1'b0;
      bus.mem_wdata = '0;
      bus.mem_owner = 1'b0;
      bus.sys_start = 1'b0;
      load_beat     = 1'b0;
      rd_issue      = 1'b0;
      out_beat      = 1'b0;
      tmo_hit       = (tmo_cnt == TMO_LAST);

      case (state)
         IDLE: begin
            if (start) state_nx = LOAD;
         end
         LOAD: begin
            bus.in_ready  = 1'b1;
            bus.mem_addr  = addr_cnt;
            bus.mem_wdata = bus.in_data;
            if (bus.in_valid) begin
               load_beat  = 1'b1;
               bus.mem_wr = 1'b1;
               if (addr_cnt == LAST) state_nx = KICK;
            end
         end
         KICK: begin
            bus.mem_owner = 1'b1;
            bus.sys_start = 1'b1;
            state_nx      = RUN_WAIT;
         end
         RUN_WAIT: begin
            bus.mem_owner = 1'b1;
            // A completion in the timeout cycle wins over the timeout.
            if (bus.sys_done) state_nx = bus.sys_fail ? FINISH : DRAIN;
            else if (tmo_hit) state_nx = FINISH;
         end
         DRAIN: begin
            bus.mem_addr  = addr_cnt;
            rd_issue      = ~addr_end & sk_ready;
            bus.out_valid = sk_valid;
            out_beat      = sk_valid & bus.out_ready;
            if (out_beat && (beat_cnt == LAST)) state_nx = FINISH;
         end
         FINISH: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_cnt <= '0;
         addr_end <= 1'b0;
         beat_cnt <= '0;
         tmo_cnt  <= '0;
         rd_pend  <= 1'b0;
         err_q    <= ERR_OK;
      end else begin
         rd_pend <= rd_issue;
         case (state)
            IDLE: begin
               if (start) begin
                  addr_cnt <= '0;
                  addr_end <= 1'b0;
                  beat_cnt <= '0;
                  err_q    <= ERR_OK;
               end
            end
            LOAD: begin
               if (load_beat && (addr_cnt != LAST)) addr_cnt <= addr_cnt + AW'(1);
            end
            KICK: begin
               tmo_cnt <= '0;
            end
            RUN_WAIT: begin
               if (!tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
               if (bus.sys_done) begin
                  if (bus.sys_fail) begin
                     err_q <= ERR_SING;
                  end else begin
                     addr_cnt <= '0;
                     addr_end <= 1'b0;
                     beat_cnt <= '0;
                  end
               end else if (tmo_hit) begin
                  err_q <= ERR_TMO;
               end
            end
            DRAIN: begin
               // The read address holds at ROWS-1 once the last read issues.
               if (rd_issue) begin
                  if (addr_cnt == LAST) addr_end <= 1'b1;
                  else                  addr_cnt <= addr_cnt + AW'(1);
               end
               if (out_beat && (beat_cnt != LAST)) beat_cnt <= beat_cnt + AW'(1);
            end
            FINISH: begin
               addr_cnt <= '0;
               addr_end <= 1'b0;
               beat_cnt <= '0;
               tmo_cnt  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_seq_ctrl.sv
// Directed bench for sys_seq_ctrl: two instances (long and short timeout)
// sharing one memory model, with a queue holding expected drain words.
module tb_sys_seq_ctrl;

   localparam int ROWS = 4;
   localparam int W    = 32;
   localparam int AW   = 2;

   logic clk;
   logic rst;
   logic sel;
   logic start;
   logic [W-1:0] in_data;
   logic in_valid;
   logic out_ready;
   logic sys_done;
   logic sys_fail;

   logic done_a, done_b;
   logic [1:0] err_a, err_b;

   logic [W-1:0] mem [ROWS];
   logic [W-1:0] rdata_q;

   logic [W-1:0] q [$];
   int errors;
   int checks;

   sys_seq_ctrl_if #(.W(W), .AW(AW)) bus_a ();
   sys_seq_ctrl_if #(.W(W), .AW(AW)) bus_b ();

   sys_seq_ctrl #(.ROWS(ROWS), .W(W), .TIMEOUT(65535), .AW(AW)) dut_a (
      .clk   (clk),
      .rst   (rst),
      .start (start & ~sel),
      .done  (done_a),
      .err   (err_a),
      .bus   (bus_a)
   );

   sys_seq_ctrl #(.ROWS(ROWS), .W(W), .TIMEOUT(10), .AW(AW)) dut_b (
      .clk   (clk),
      .rst   (rst),
      .start (start & sel),
      .done  (done_b),
      .err   (err_b),
      .bus   (bus_b)
   );

   assign bus_a.in_data   = in_data;
   assign bus_a.in_valid  = in_valid;
   assign bus_a.out_ready = out_ready;
   assign bus_a.mem_rdata = rdata_q;
   assign bus_a.sys_done  = sys_done & ~sel;
   assign bus_a.sys_fail  = sys_fail;
   assign bus_b.in_data   = in_data;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.out_ready = out_ready;
   assign bus_b.mem_rdata = rdata_q;
   assign bus_b.sys_done  = sys_done & sel;
   assign bus_b.sys_fail  = sys_fail;

   logic          o_done, o_in_ready, o_out_valid, o_mem_wr, o_owner, o_sys_start;
   logic [1:0]    o_err;
   logic [W-1:0]  o_out_data, o_wdata;
   logic [AW-1:0] o_addr;

   assign o_done      = sel ? done_b            : done_a;
   assign o_err       = sel ? err_b             : err_a;
   assign o_in_ready  = sel ? bus_b.in_ready    : bus_a.in_ready;
   assign o_out_valid = sel ? bus_b.out_valid   : bus_a.out_valid;
   assign o_out_data  = sel ? bus_b.out_data    : bus_a.out_data;
   assign o_mem_wr    = sel ? bus_b.mem_wr      : bus_a.mem_wr;
   assign o_addr      = sel ? bus_b.mem_addr    : bus_a.mem_addr;
   assign o_wdata     = sel ? bus_b.mem_wdata   : bus_a.mem_wdata;
   assign o_owner     = sel ? bus_b.mem_owner   : bus_a.mem_owner;
   assign o_sys_start = sel ? bus_b.sys_start   : bus_a.sys_start;

   // Memory with one-cycle registered read.
   always_ff @(posedge clk) begin
      if (o_mem_wr) mem[o_addr] <= o_wdata;
      rdata_q <= mem[o_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, req);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_done"},      32'(o_done),      32'd0);
      chk({tag, "_in_ready"},  32'(o_in_ready),  32'd0);
      chk({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
      chk({tag, "_mem_wr"},    32'(o_mem_wr),    32'd0);
      chk({tag, "_mem_addr"},  32'(o_addr),      32'd0);
      chk({tag, "_owner"},     32'(o_owner),     32'd0);
      chk({tag, "_sys_start"}, 32'(o_sys_start), 32'd0);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_ready", 32'(o_in_ready), 32'd1);
      chk("start_err_clr",  32'(o_err),      32'd0);
   endtask

   task automatic load(input logic [W-1:0] base, input int n, input bit bubble);
      for (int i = 0; i < n; i++) begin
         if (bubble && i == 2) begin
            in_valid = 1'b0;
            #1;
            chk("load_bubble_wr", 32'(o_mem_wr), 32'd0);
            tick();
         end
         in_valid = 1'b1;
         in_data  = base + W'(i);
         #1;
         chk("load_wr",   32'(o_mem_wr), 32'd1);
         chk("load_addr", 32'(o_addr),   32'(i));
         q.push_back(base + W'(i));
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Entered on the KICK cycle; sys_done is driven in RUN_WAIT cycle n.
   task automatic kick_and_wait(input int n, input bit fail, input bit poke);
      chk("kick_sys_start", 32'(o_sys_start), 32'd1);
      chk("kick_owner",     32'(o_owner),     32'd1);
      chk("kick_in_ready",  32'(o_in_ready),  32'd0);
      for (int m = 1; m <= n; m++) begin
         tick();
         start = 1'b0;
         if (m == 1) begin
            chk("run_sys_start", 32'(o_sys_start), 32'd0);
            chk("run_owner",     32'(o_owner),     32'd1);
         end
         if (poke && m == 3) start = 1'b1;
         if (m == n) begin
            sys_done = 1'b1;
            sys_fail = fail;
         end
      end
      tick();
      sys_done = 1'b0;
      sys_fail = 1'b0;
      start    = 1'b0;
   endtask

   task automatic drain(input bit toggle);
      int i;
      logic [W-1:0] req;
      i = 0;
      chk("drain_owner", 32'(o_owner), 32'd0);
      while (q.size() != 0 && i < 100) begin
         out_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
         #1;
         if (o_out_valid && out_ready) begin
            req = q.pop_front();
            chk("drain_data", o_out_data, req);
         end
         tick();
         i++;
      end
      out_ready = 1'b0;
      chk("drain_left", 32'(q.size()), 32'd0);
      chk("finish_done",  32'(o_done),      32'd1);
      chk("finish_valid", 32'(o_out_valid), 32'd0);
      chk("finish_err",   32'(o_err),       32'd0);
      tick();
      chk("post_done",     32'(o_done),      32'd0);
      chk("post_in_ready", 32'(o_in_ready),  32'd0);
      chk("post_valid",    32'(o_out_valid), 32'd0);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      sel       = 1'b0;
      start     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sys_done  = 1'b0;
      sys_fail  = 1'b0;
      repeat (3) tick();
      chk("rst_err_a", 32'(o_err), 32'd0);
      check_idle_outputs("rst_a");
      sel = 1'b1;
      #1;
      check_idle_outputs("rst_b");
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // Basic job, out_ready held high.
      do_start();
      load(32'h0000_000A, ROWS, 1'b0);
      kick_and_wait(20, 1'b0, 1'b0);
      drain(1'b0);

      // Toggling backpressure, input bubble, start poked during RUN_WAIT.
      do_start();
      load(32'hC0DE_0010, ROWS, 1'b1);
      kick_and_wait(20, 1'b0, 1'b1);
      drain(1'b1);

      // Systemizer failure.
      do_start();
      load(32'h1234_0000, ROWS, 1'b0);
      kick_and_wait(5, 1'b1, 1'b0);
      chk("fail_done",  32'(o_done),      32'd1);
      chk("fail_err",   32'(o_err),       32'd1);
      chk("fail_owner", 32'(o_owner),     32'd0);
      chk("fail_valid", 32'(o_out_valid), 32'd0);
      q.delete();
      tick();
      chk("fail_post_done", 32'(o_done), 32'd0);
      chk("fail_err_held",  32'(o_err),  32'd1);

      // Stray sys_done in IDLE.
      sys_done = 1'b1;
      tick();
      sys_done = 1'b0;
      chk("stray_err",   32'(o_err), 32'd1);
      check_idle_outputs("stray1");
      tick();
      check_idle_outputs("stray2");

      // Timeout on the TIMEOUT=10 instance.
      sel = 1'b1;
      do_start();
      load(32'hDEAD_0000, ROWS, 1'b0);
      chk("tmo_kick", 32'(o_sys_start), 32'd1);
      for (int m = 1; m <= 10; m++) begin
         tick();
         chk("tmo_wait_done",  32'(o_done),  32'd0);
         chk("tmo_wait_owner", 32'(o_owner), 32'd1);
      end
      tick();
      chk("tmo_done",  32'(o_done),      32'd1);
      chk("tmo_err",   32'(o_err),       32'd2);
      chk("tmo_owner", 32'(o_owner),     32'd0);
      chk("tmo_valid", 32'(o_out_valid), 32'd0);
      q.delete();
      tick();
      chk("tmo_post_done", 32'(o_done), 32'd0);
      chk("tmo_err_held",  32'(o_err),  32'd2);

      // sys_done in the timeout cycle wins.
      do_start();
      load(32'hBEEF_0100, ROWS, 1'b0);
      kick_and_wait(10, 1'b0, 1'b0);
      drain(1'b0);
      sel = 1'b0;
      tick();

      // Reset mid-LOAD, then a fresh job.
      do_start();
      load(32'h7777_0000, 2, 1'b0);
      rst = 1'b1;
      tick();
      chk("midrst_err", 32'(o_err), 32'd0);
      check_idle_outputs("midrst");
      rst = 1'b0;
      q.delete();
      tick();
      check_idle_outputs("midrst_idle");
      do_start();
      load(32'h5555_0040, ROWS, 1'b0);
      kick_and_wait(20, 1'b0, 1'b0);
      drain(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sys_seq_ctrl.md
SYS_SEQ_CTRL -- requirements
Module: sys_seq_ctrl

Interface
REQ-001 Parameter ROWS, default 8: matrix words loaded into and drained from the systemizer memory per job.
REQ-002 Parameter W, default 32: memory/stream word width in bits.
REQ-003 Parameter TIMEOUT, default 65535: maximum RUN_WAIT cycles before abort.
REQ-004 Parameter AW, default clog2(ROWS): memory address width.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  job request; sampled only in IDLE.
REQ-008 done  out  1  one-cycle pulse at job end (success or error).
REQ-009 err  out  2  job result held until next start: 0 ok, 1 singular, 2 timeout.
REQ-010 in_data/in_valid/in_ready  in/in/out  W/1/1  load stream; beat transfers when valid&ready.
REQ-011 out_data/out_valid/out_ready  out/out/in  W/1/1  drain stream; same transfer rule.
REQ-012 mem_addr/mem_wr/mem_wdata  out  AW/1/W  controller memory port.
REQ-013 mem_rdata  in  W  read data, valid exactly one cycle after address issue.
REQ-014 mem_owner  out  1  0 = controller owns memory, 1 = systemizer owns it.
REQ-015 sys_start  out  1  one-cycle start pulse to systemizer.
REQ-016 sys_done/sys_fail  in  1/1  systemizer completion pulse; sys_fail valid with sys_done.

Function
REQ-017 States SHALL be IDLE, LOAD, KICK, RUN_WAIT, DRAIN, FINISH.
REQ-018 IDLE: start=1 -> LOAD, address counter cleared, err cleared; start in other states ignored.
REQ-019 LOAD: in_ready=1; each beat writes in_data to address 0..ROWS-1 in order (mem_wr=1 that cycle); after beat ROWS-1 -> KICK.
REQ-020 KICK: mem_owner=1, sys_start=1 for exactly one cycle, then RUN_WAIT; mem_owner stays 1 through RUN_WAIT.
REQ-021 RUN_WAIT: cycle counter increments; sys_done=1 & sys_fail=0 -> DRAIN; sys_done=1 & sys_fail=1 -> FINISH with err=1.
REQ-022 RUN_WAIT: counter reaching TIMEOUT with no sys_done -> FINISH with err=2; sys_done in that same cycle takes priority over timeout.
REQ-023 sys_done/sys_fail outside RUN_WAIT SHALL be ignored.
REQ-024 DRAIN: mem_owner=0; reads addresses 0..ROWS-1 in order, data presented on out_data in address order, none dropped or duplicated under any out_ready pattern.
REQ-025 DRAIN: read issue SHALL stall when skid buffer cannot accept data arriving next cycle; with out_ready held 1, one beat per cycle after 1-cycle latency.
REQ-026 DRAIN -> FINISH after beat ROWS-1 transfers; FINISH asserts done one cycle, then IDLE.
REQ-027 in_ready=0 outside LOAD; out_valid=0 outside DRAIN; mem_wr=0 outside LOAD.
REQ-028 Address and beat counters SHALL not wrap; ROWS-1 is terminal.

Reset
REQ-029 rst=1 SHALL force IDLE within one cycle from any state, including mid-LOAD/RUN_WAIT/DRAIN.
REQ-030 Reset values: done=0, err=0, in_ready=0, out_valid=0, mem_wr=0, mem_addr=0, mem_owner=0, sys_start=0, counters 0, skid buffer empty.

Structure
REQ-031 State encoding, err codes (ERR_OK/ERR_SING/ERR_TMO) SHALL live in shared package sys_seq_pkg.
REQ-032 Drain backpressure SHALL use one sub-module, skid_buf (2-entry, W wide, valid/ready both sides).
REQ-033 No combinational path from out_ready to mem_addr beyond skid_buf ready.

Verification
REQ-034 ROWS=4: start, load 0xA,0xB,0xC,0xD, sys_done 20 cycles after sys_start, out_ready=1 -> out 0xA..0xD, done pulse, err=0.
REQ-035 Same, out_ready toggling 1,0,0,1,... -> identical ordered output, no duplicates.
REQ-036 sys_done with sys_fail=1 -> no out_valid, done pulse, err=1, mem_owner=0.
REQ-037 TIMEOUT=10, no sys_done -> done 11th RUN_WAIT cycle, err=2; sys_done in the timeout cycle -> DRAIN, err=0.
REQ-038 rst after 2 LOAD beats -> IDLE next cycle, all outputs reset values; fresh job then completes correctly.
REQ-039 start asserted during RUN_WAIT and stray sys_done in IDLE -> no state change.
